cpu_exec_sequencer: RTL
=======================

# cpu_exec_sequencer

Multi-cycle fetch/decode/execute/writeback controller for the 16-bit CPU.
- Fetches instructions over a req/ack instruction-memory port and decodes them.
- Reads operands from an internal register file and drives the ALU's A, B and ALUOp inputs.
- Consumes the ALU's Result and Zero outputs for register writeback and the zero flag.
- Sits directly around the combinational ALU: upstream of its inputs, downstream of its outputs.

## Interface
- `DATA_W`, 16, datapath width; must match the ALU.
- `PC_W`, 8, program counter / instruction address width.
- `NREGS`, 16, register count; addressed by 4-bit fields.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request; combinational, equals (state == FETCH).
- `imem_addr`  out  PC_W  fetch address; equals pc.
- `imem_ack`  in  1  memory has `imem_data` valid this cycle.
- `imem_data`  in  16  instruction word.
- `alu_a`  out  DATA_W  ALU operand A; registered.
- `alu_b`  out  DATA_W  ALU operand B; registered.
- `alu_op`  out  3  ALUOp; registered. 000 ADD, 001 SUB, 010 AND, 011 OR.
- `alu_result`  in  DATA_W  ALU Result.
- `alu_zero`  in  1  ALU Zero flag.
- `zero_flag`  out  1  architectural zero flag.
- `pc`  out  PC_W  current program counter.
- `halted`  out  1  high in HALT.

## Operation
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2; imm8 = [7:0].
- Opcodes 0x0–0x3 are ADD/SUB/AND/OR: rd = rs1 op rs2, with ALUOp = opcode[2:0].
- 0x4 LDI: rd = zero-extended imm8.
- 0x5 BZ: pc = imm8[PC_W-1:0] if zero_flag, else pc+1.
- 0x6 JMP: pc = imm8[PC_W-1:0].
- 0xF HALT.
- All other opcodes are NOP (pc+1).
- Register file: R0 reads as 0; writes to R0 are discarded.
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - Wait for `imem_ack`.
  - On the ack edge: IR <= `imem_data`, go to DECODE.
  - `imem_addr` is stable while waiting.
- DECODE:
  - ALU opcode: `alu_a` <= R[rs1], `alu_b` <= R[rs2], `alu_op` <= opcode[2:0]; go to EXECUTE.
  - LDI/BZ/JMP/NOP: perform the register write and/or pc update in this cycle; go to FETCH.
  - HALT: go to HALT; pc is not advanced.
- EXECUTE:
  - ALU inputs held stable for one cycle.
  - On the exit edge: capture `alu_result` and `alu_zero` into holding registers; go to WRITEBACK.
- WRITEBACK:
  - R[rd] <= captured result.
  - `zero_flag` <= captured zero.
  - pc <= pc+1; go to FETCH.
- HALT: absorbing state; only reset leaves it.
- `zero_flag` is written only by ALU-class instructions. LDI, BZ, JMP and NOP leave it unchanged.
- pc+1 wraps from 2^PC_W−1 to 0.
- `alu_a`/`alu_b`/`alu_op` hold their last values outside DECODE→EXECUTE loading.

## Timing
- Reset (asynchronous, immediate):
  - state = FETCH, pc = 0, all registers = 0.
  - `alu_a` = `alu_b` = 0, `alu_op` = 000, `zero_flag` = 0, `halted` = 0.
  - `imem_req` is 1 during reset (state = FETCH); acks while `rst_n` is low are ignored.
- ALU instruction: ack edge + 3 cycles (DECODE, EXECUTE, WRITEBACK) until the next FETCH.
- LDI/BZ/JMP/NOP: ack edge + 1 cycle.
- Minimum fetch is 1 cycle (ack in the first FETCH cycle).
- A register written in WRITEBACK or DECODE is readable by the next instruction's DECODE; no bypass is needed.
- Reset mid-instruction: the in-flight instruction is abandoned with no writeback and no pc update.
- `halted` rises the cycle after DECODE of HALT. While halted, `imem_req` = 0.

## Structure
- Package `cpu_pkg`:
  - opcode constants;
  - ALUOp constants (000–011, matching the ALU);
  - state enum;
  - `DATA_W`/`PC_W` defaults.
- Sub-module `reg_file`:
  - NREGS × DATA_W;
  - two asynchronous read ports, one synchronous write port with enable;
  - R0 hardwired to 0;
  - asynchronous active-low clear.
- The ALU is external; this block only connects to its ports.

## Test plan
- Reset check: hold `rst_n` low → `pc`=0, `alu_op`=000, `alu_a`=`alu_b`=0, `zero_flag`=0, `halted`=0, `imem_req`=1.
- SUB through the ALU: LDI R1,5; LDI R2,3; SUB R3,R1,R2 → in EXECUTE `alu_a`=5, `alu_b`=3, `alu_op`=001. Then ADD R4,R3,R0 → `alu_a`=2. `zero_flag`=0.
- Zero flag and branch: SUB R5,R1,R1 → `zero_flag`=1. Then BZ 0x20 → `pc`=0x20. After an ADD giving a nonzero result, BZ 0x40 → `pc` = pc+1.
- Slow fetch: delay `imem_ack` by 3 cycles → state stays FETCH and `imem_addr` is stable. The ALU instruction completes exactly 3 cycles after the ack edge.
- Boundaries:
  - LDI R0,7 then ADD R1,R0,R0 → `alu_a`=0.
  - JMP 0xFF then NOP → `pc`=0x00 (wrap).
  - HALT → `halted`=1, `imem_req`=0, no further fetches.
- Mid-instruction reset: assert `rst_n` low during EXECUTE → outputs return to reset values immediately. After release: the rd register is still 0 and fetch restarts at `pc`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit CPU sequencer.
package cpu_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_PC_W   = 8;
   localparam int DEF_NREGS  = 16;

   // Instruction opcodes, ir[15:12]
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_LDI  = 4'h4;
   localparam logic [3:0] OP_BZ   = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_HALT = 4'hF;

   // ALUOp encodings understood by the external ALU
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

endpackage

// File: rtl/reg_file.sv
// Register file: two async read ports, one sync write port, R0 reads as zero.
module reg_file
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     ra1,
   input  logic [AW-1:0]     ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] mem [NREGS];

   // Storage: cleared on reset, written when enabled except for R0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   // Read ports with R0 forced to zero
   always_comb begin
      rd1 = (ra1 == '0) ? '0 : mem[ra1];
      rd2 = (ra2 == '0) ? '0 : mem[ra2];
   end

endmodule

// File: rtl/cpu_exec_sequencer.sv
// Fetch/decode/execute/writeback controller wrapped around an external ALU.
module cpu_exec_sequencer
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PC_W   = DEF_PC_W,
   parameter int NREGS  = DEF_NREGS
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              zero_flag,
   output logic [PC_W-1:0]   pc,
   output logic              halted
);

   state_t            state;
   logic [15:0]       ir;
   logic [DATA_W-1:0] res_hold;
   logic              zero_hold;

   logic [3:0]        opcode;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic [DATA_W-1:0] imm_ext;
   logic              rf_we;
   logic [DATA_W-1:0] rf_wd;

   assign opcode    = ir[15:12];
   assign imm_ext   = {{(DATA_W-8){1'b0}}, ir[7:0]};
   assign imem_req  = (state == S_FETCH);
   assign imem_addr = pc;

   // Register write comes from LDI in DECODE or the ALU result in WRITEBACK
   always_comb begin
      rf_we = 1'b0;
      rf_wd = imm_ext;
      if (state == S_WRITEBACK) begin
         rf_we = 1'b1;
         rf_wd = res_hold;
      end else if ((state == S_DECODE) && (opcode == OP_LDI)) begin
         rf_we = 1'b1;
      end
   end

   reg_file #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (ir[7:4]),
      .ra2   (ir[3:0]),
      .rd1   (rdata1),
      .rd2   (rdata2),
      .we    (rf_we),
      .wa    (ir[11:8]),
      .wd    (rf_wd)
   );

   // Sequencer FSM with registered ALU drive, pc and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         pc        <= '0;
         ir        <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= ALU_ADD;
         zero_flag <= 1'b0;
         res_hold  <= '0;
         zero_hold <= 1'b0;
         halted    <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_data;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     alu_a  <= rdata1;
                     alu_b  <= rdata2;
                     alu_op <= opcode[2:0];
                     state  <= S_EXECUTE;
                  end
                  OP_BZ: begin
                     pc    <= zero_flag ? ir[PC_W-1:0] : pc + 1'b1;
                     state <= S_FETCH;
                  end
                  OP_JMP: begin
                     pc    <= ir[PC_W-1:0];
                     state <= S_FETCH;
                  end
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: begin
                     pc    <= pc + 1'b1;
                     state <= S_FETCH;
                  end
               endcase
            end
            S_EXECUTE: begin
               res_hold  <= alu_result;
               zero_hold <= alu_zero;
               state     <= S_WRITEBACK;
            end
            S_WRITEBACK: begin
               zero_flag <= zero_hold;
               pc        <= pc + 1'b1;
               state     <= S_FETCH;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule
